// File: rtl/l1_trigger_intercon.sv
// Wishbone bridge for the L1 trigger block: one 15-bit host port decoded into
// four 13-bit target spaces, one registered access in flight at a time.
module l1_trigger_intercon #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        clock_enabled_i,

    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [14:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o,

    output logic        thresh_cyc_o,
    output logic        thresh_stb_o,
    output logic        thresh_we_o,
    output logic [12:0] thresh_adr_o,
    output logic [31:0] thresh_dat_o,
    output logic [3:0]  thresh_sel_o,
    input  logic [31:0] thresh_dat_i,
    input  logic        thresh_ack_i,
    input  logic        thresh_err_i,
    input  logic        thresh_rty_i,

    output logic        control_cyc_o,
    output logic        control_stb_o,
    output logic        control_we_o,
    output logic [12:0] control_adr_o,
    output logic [31:0] control_dat_o,
    output logic [3:0]  control_sel_o,
    input  logic [31:0] control_dat_i,
    input  logic        control_ack_i,
    input  logic        control_err_i,
    input  logic        control_rty_i,

    output logic        agc_cyc_o,
    output logic        agc_stb_o,
    output logic        agc_we_o,
    output logic [12:0] agc_adr_o,
    output logic [31:0] agc_dat_o,
    output logic [3:0]  agc_sel_o,
    input  logic [31:0] agc_dat_i,
    input  logic        agc_ack_i,
    input  logic        agc_err_i,
    input  logic        agc_rty_i,

    output logic        bq_cyc_o,
    output logic        bq_stb_o,
    output logic        bq_we_o,
    output logic [12:0] bq_adr_o,
    output logic [31:0] bq_dat_o,
    output logic [3:0]  bq_sel_o,
    input  logic [31:0] bq_dat_i,
    input  logic        bq_ack_i,
    input  logic        bq_err_i,
    input  logic        bq_rty_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] SEL_CONTROL = 2'd1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    tsel;
    logic          active;
    logic [12:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          ack_q;
    logic          err_q;
    logic          rty_q;
    logic [31:0]   rdat_q;
    logic [CW-1:0] wait_cnt;
    logic          sync1;
    logic          sync2;
    logic [3:0]    hit;

    logic          sel_ack;
    logic          sel_err;
    logic          sel_rty;
    logic [31:0]   sel_dat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= clock_enabled_i;
            sync2 <= sync1;
        end
    end

    // Only the addressed target's response is looked at.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        sel_dat = '0;
        case (tsel)
            2'd0: begin
                sel_ack = thresh_ack_i;
                sel_err = thresh_err_i;
                sel_rty = thresh_rty_i;
                sel_dat = thresh_dat_i;
            end
            2'd1: begin
                sel_ack = control_ack_i;
                sel_err = control_err_i;
                sel_rty = control_rty_i;
                sel_dat = control_dat_i;
            end
            2'd2: begin
                sel_ack = agc_ack_i;
                sel_err = agc_err_i;
                sel_rty = agc_rty_i;
                sel_dat = agc_dat_i;
            end
            default: begin
                sel_ack = bq_ack_i;
                sel_err = bq_err_i;
                sel_rty = bq_rty_i;
                sel_dat = bq_dat_i;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            tsel     <= 2'd0;
            active   <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            rdat_q   <= '0;
            wait_cnt <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q    <= wb_adr_i[12:0];
                        dat_q    <= wb_dat_i;
                        sel_q    <= wb_sel_i;
                        we_q     <= wb_we_i;
                        tsel     <= wb_adr_i[14:13];
                        rdat_q   <= '0;
                        wait_cnt <= '0;
                        // Stopped generator clock: answer locally so the host never hangs.
                        if (wb_adr_i[14:13] == SEL_CONTROL && !sync2) begin
                            ack_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            active <= 1'b1;
                            state  <= FWD;
                        end
                    end
                end
                FWD: begin
                    if (!wb_cyc_i) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else if (sel_err) begin
                        err_q  <= 1'b1;
                        active <= 1'b0;
                        state  <= RESP;
                    end else if (sel_rty) begin
                        rty_q  <= 1'b1;
                        active <= 1'b0;
                        state  <= RESP;
                    end else if (sel_ack) begin
                        ack_q  <= 1'b1;
                        rdat_q <= sel_dat;
                        active <= 1'b0;
                        state  <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err_q  <= 1'b1;
                        active <= 1'b0;
                        state  <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // A host that dropped its cycle during the response slot gets nothing back.
    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = err_q & wb_cyc_i;
    assign wb_rty_o = rty_q & wb_cyc_i;
    assign wb_dat_o = wb_ack_o ? rdat_q : 32'd0;

    assign hit = active ? (4'b0001 << tsel) : 4'b0000;

    assign thresh_cyc_o  = hit[0];
    assign thresh_stb_o  = hit[0];
    assign thresh_we_o   = hit[0] & we_q;
    assign thresh_adr_o  = adr_q;
    assign thresh_dat_o  = dat_q;
    assign thresh_sel_o  = sel_q;

    assign control_cyc_o = hit[1];
    assign control_stb_o = hit[1];
    assign control_we_o  = hit[1] & we_q;
    assign control_adr_o = adr_q;
    assign control_dat_o = dat_q;
    assign control_sel_o = sel_q;

    assign agc_cyc_o     = hit[2];
    assign agc_stb_o     = hit[2];
    assign agc_we_o      = hit[2] & we_q;
    assign agc_adr_o     = adr_q;
    assign agc_dat_o     = dat_q;
    assign agc_sel_o     = sel_q;

    assign bq_cyc_o      = hit[3];
    assign bq_stb_o      = hit[3];
    assign bq_we_o       = hit[3] & we_q;
    assign bq_adr_o      = adr_q;
    assign bq_dat_o      = dat_q;
    assign bq_sel_o      = sel_q;

endmodule

// File: tb/tb_l1_trigger_intercon.sv
// Bench for l1_trigger_intercon: table of host accesses against behavioural
// targets, host responses checked through a scoreboard queue.
module tb_l1_trigger_intercon;

    localparam int TIMEOUT_CYCLES = 256;

    typedef struct {
        logic        we;
        logic [14:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        clk_en;
        int          lat;
        logic [2:0]  kind;
        logic [31:0] tdat;
        logic        noise;
        logic [2:0]  exp_resp;
        logic [31:0] exp_dat;
        logic        exp_fwd;
    } vec_t;

    typedef struct packed {
        logic [2:0]  resp;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clock_enabled_i = 1'b0;
    logic wb_cyc_i = 1'b0;
    logic wb_stb_i = 1'b0;
    logic wb_we_i = 1'b0;
    logic [14:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] wb_dat_o;

    logic [3:0] t_ack = '0;
    logic [3:0] t_err = '0;
    logic [3:0] t_rty = '0;
    logic [3:0][31:0] t_dat = '0;
    logic [3:0] t_cyc, t_stb, t_we;
    logic [3:0][12:0] t_adr;
    logic [3:0][31:0] t_wdat;
    logic [3:0][3:0]  t_sel;

    exp_t sb_q[$];
    vec_t vecs [12];
    int tests = 0;
    int fails = 0;
    int resp_events = 0;

    always #5 clk = ~clk;

    l1_trigger_intercon #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .clock_enabled_i(clock_enabled_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
        .thresh_cyc_o(t_cyc[0]), .thresh_stb_o(t_stb[0]), .thresh_we_o(t_we[0]),
        .thresh_adr_o(t_adr[0]), .thresh_dat_o(t_wdat[0]), .thresh_sel_o(t_sel[0]),
        .thresh_dat_i(t_dat[0]), .thresh_ack_i(t_ack[0]), .thresh_err_i(t_err[0]), .thresh_rty_i(t_rty[0]),
        .control_cyc_o(t_cyc[1]), .control_stb_o(t_stb[1]), .control_we_o(t_we[1]),
        .control_adr_o(t_adr[1]), .control_dat_o(t_wdat[1]), .control_sel_o(t_sel[1]),
        .control_dat_i(t_dat[1]), .control_ack_i(t_ack[1]), .control_err_i(t_err[1]), .control_rty_i(t_rty[1]),
        .agc_cyc_o(t_cyc[2]), .agc_stb_o(t_stb[2]), .agc_we_o(t_we[2]),
        .agc_adr_o(t_adr[2]), .agc_dat_o(t_wdat[2]), .agc_sel_o(t_sel[2]),
        .agc_dat_i(t_dat[2]), .agc_ack_i(t_ack[2]), .agc_err_i(t_err[2]), .agc_rty_i(t_rty[2]),
        .bq_cyc_o(t_cyc[3]), .bq_stb_o(t_stb[3]), .bq_we_o(t_we[3]),
        .bq_adr_o(t_adr[3]), .bq_dat_o(t_wdat[3]), .bq_sel_o(t_sel[3]),
        .bq_dat_i(t_dat[3]), .bq_ack_i(t_ack[3]), .bq_err_i(t_err[3]), .bq_rty_i(t_rty[3])
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_host_resp"}, {wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o}, 64'd0);
        checkOutput({tag, "_tgt_ctrl"}, {t_cyc, t_stb, t_we}, 64'd0);
        checkOutput({tag, "_tgt_adr"}, t_adr, 64'd0);
        checkOutput({tag, "_tgt_dat"}, t_wdat[0] | t_wdat[1] | t_wdat[2] | t_wdat[3], 64'd0);
        checkOutput({tag, "_tgt_sel"}, t_sel, 64'd0);
    endtask

    // Response sampled mid-cycle, clear of both the clock edge and host input changes.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (wb_ack_o || wb_err_o || wb_rty_o) begin
            resp_events++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_resp", {wb_err_o, wb_rty_o, wb_ack_o}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("resp_kind", {wb_err_o, wb_rty_o, wb_ack_o}, e.resp);
                checkOutput("resp_dat", wb_dat_o, e.dat);
            end
        end
    end

    // One host access with the addressed target answering after v.lat cycles;
    // abort_after >= 0 drops the host cycle that many cycles into the forward.
    task automatic applyStimulus(input vec_t v, input int idx, input bit settle, input int abort_after);
        int tsel;
        int c;
        int resp_c;
        int ev0;
        bit seen;
        bit done;
        logic [3:0] mask;
        logic stb_at_resp;
        logic [12:0] cap_adr;
        logic [31:0] cap_dat;
        logic [3:0] cap_sel;
        logic cap_we;
        exp_t e;
        string p;

        p = $sformatf("v%0d", idx);
        tsel = int'(v.adr[14:13]);
        clock_enabled_i = v.clk_en;
        if (settle) repeat (3) @(negedge clk);
        if (abort_after < 0) begin
            e.resp = v.exp_resp;
            e.dat = v.exp_dat;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            t_dat[k] = (k == tsel) ? v.tdat : (32'hBAD0_0000 | 32'(k));
            t_ack[k] = v.noise && (k != tsel);
            t_err[k] = v.noise && (k != tsel);
            t_rty[k] = 1'b0;
        end
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = v.we;
        wb_adr_i = v.adr;
        wb_dat_i = v.wdat;
        wb_sel_i = v.sel;
        seen = 0; done = 0; c = 0; resp_c = -1; mask = '0; stb_at_resp = 1'b0;
        cap_adr = '0; cap_dat = '0; cap_sel = '0; cap_we = 1'b0;
        ev0 = resp_events;

        for (int n = 1; n <= TIMEOUT_CYCLES + 50 && !done; n++) begin
            @(negedge clk);
            if (seen) c++;
            mask |= t_stb;
            if (wb_ack_o || wb_err_o || wb_rty_o) begin
                resp_c = seen ? c : n;
                stb_at_resp = t_cyc[tsel] | t_stb[tsel];
                done = 1;
            end else if (abort_after >= 0 && seen && c == abort_after) begin
                done = 1;
            end else begin
                if (!seen && t_stb[tsel]) begin
                    seen = 1;
                    c = 0;
                    cap_adr = t_adr[tsel];
                    cap_dat = t_wdat[tsel];
                    cap_sel = t_sel[tsel];
                    cap_we = t_we[tsel];
                end
                t_ack[tsel] = seen && (c == v.lat) && v.kind[0];
                t_rty[tsel] = seen && (c == v.lat) && v.kind[1];
                t_err[tsel] = seen && (c == v.lat) && v.kind[2];
            end
        end
        t_ack = '0; t_err = '0; t_rty = '0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;

        if (abort_after >= 0) begin
            repeat (5) @(negedge clk);
            checkOutput({p, "_abort_no_resp"}, 64'(resp_events - ev0), 64'd0);
            checkOutput({p, "_abort_tgt_idle"}, {t_cyc, t_stb}, 64'd0);
            checkOutput({p, "_abort_was_fwd"}, mask, 64'(4'b0001 << tsel));
        end else begin
            checkOutput({p, "_resp_seen"}, done, 64'd1);
            checkOutput({p, "_strobe_mask"}, mask, v.exp_fwd ? 64'(4'b0001 << tsel) : 64'd0);
            if (v.exp_fwd) begin
                checkOutput({p, "_latency"}, 64'(resp_c),
                            64'((v.kind == 3'b000) ? TIMEOUT_CYCLES : v.lat + 1));
                checkOutput({p, "_stb_at_resp"}, stb_at_resp, 64'd0);
                checkOutput({p, "_adr"}, cap_adr, v.adr[12:0]);
                checkOutput({p, "_we"}, cap_we, v.we);
                checkOutput({p, "_sel"}, cap_sel, v.sel);
                if (v.we) checkOutput({p, "_wdat"}, cap_dat, v.wdat);
            end
            @(negedge clk);
            checkOutput({p, "_idle_after"}, {t_cyc, t_stb}, 64'd0);
        end
    endtask

    initial begin
        vec_t v;
        //           we    adr       wdat          sel   en   lat kind    tdat          noise exp     exp_dat       fwd
        vecs[0]  = '{1'b0, 15'h0004, 32'h0,        4'hF, 1'b1, 3, 3'b001, 32'h12345678, 1'b0, 3'b001, 32'h12345678, 1'b1};
        vecs[1]  = '{1'b1, 15'h2010, 32'hA5A5A5A5, 4'hF, 1'b1, 1, 3'b001, 32'h0,        1'b0, 3'b001, 32'h0,        1'b1};
        vecs[2]  = '{1'b1, 15'h4020, 32'hA5A5A5A5, 4'h3, 1'b1, 0, 3'b001, 32'h0,        1'b0, 3'b001, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 15'h6030, 32'hA5A5A5A5, 4'hC, 1'b1, 2, 3'b001, 32'h0,        1'b1, 3'b001, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 15'h2000, 32'h0,        4'hF, 1'b0, 0, 3'b001, 32'hFFFFFFFF, 1'b0, 3'b001, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 15'h6000, 32'h0,        4'hF, 1'b1, 1, 3'b101, 32'h11111111, 1'b0, 3'b100, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 15'h0100, 32'h0,        4'h1, 1'b1, 4, 3'b010, 32'h22222222, 1'b0, 3'b010, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 15'h4000, 32'h0,        4'hF, 1'b1, 0, 3'b011, 32'h33333333, 1'b0, 3'b010, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 15'h2004, 32'h0,        4'hF, 1'b1, 2, 3'b110, 32'h44444444, 1'b0, 3'b100, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 15'h7FFC, 32'h0,        4'hF, 1'b1, 5, 3'b001, 32'hCAFEF00D, 1'b1, 3'b001, 32'hCAFEF00D, 1'b1};
        vecs[10] = '{1'b1, 15'h2008, 32'h5A5A5A5A, 4'hF, 1'b0, 0, 3'b001, 32'h0,        1'b0, 3'b001, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 15'h4008, 32'h0,        4'hF, 1'b1, 0, 3'b000, 32'h77777777, 1'b1, 3'b100, 32'h0,        1'b1};

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i, 1'b1, -1);

        // Host gives up on a bq access that is still waiting for the target.
        v = '{1'b0, 15'h6040, 32'h0, 4'hF, 1'b1, 0, 3'b000, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1};
        applyStimulus(v, 12, 1'b1, 3);

        // Reset in the middle of a forward, then generator space right after release.
        clock_enabled_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 15'h0123; wb_dat_i = 32'h0F0F0F0F; wb_sel_i = 4'hF;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_fwd", t_cyc, 64'h1);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 15'h2000, 32'h0, 4'hF, 1'b1, 0, 3'b001, 32'h55AA55AA, 1'b0, 3'b001, 32'h0, 1'b0};
        applyStimulus(v, 13, 1'b0, -1);
        v = '{1'b0, 15'h2000, 32'h0, 4'hF, 1'b1, 1, 3'b001, 32'h55AA55AA, 1'b0, 3'b001, 32'h55AA55AA, 1'b1};
        applyStimulus(v, 14, 1'b0, -1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
